// File: rtl/ita_output_writer.sv
// ita_output_writer: takes the ITA result stream (one N-lane row segment per
// beat) and writes each beat through a single-port req/gnt memory interface.
// Beats are written to a tiled row-major matrix: column tile outer, row inner.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   start_i                          job start (taken only in IDLE)
//   base_addr_i, row_stride_i        byte address of (0,0), row pitch
//   num_rows_i, num_col_tiles_i      job shape (latched on start)
//   oup_valid_i/oup_ready_o/oup_i    ITA output stream
//   mem_req_o/mem_gnt_i              memory write handshake
//   mem_addr_o/mem_wdata_o           write address / data (FIFO head)
//   busy_o, done_o                   job in flight / one-cycle job-end pulse
//   stall_cnt_o                      req-without-gnt cycle count
//
// Build option: define ITA_OUTPUT_WRITER_STALL_CNT_EN to build the saturating
// stall counter; otherwise stall_cnt_o is tied to 0.
module ita_output_writer #(
  parameter int unsigned N  = 16,
  parameter int unsigned WI = 8,
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW-1:0]   row_stride_i,
  input  logic [CW-1:0]   num_rows_i,
  input  logic [CW-1:0]   num_col_tiles_i,
  input  logic            oup_valid_i,
  output logic            oup_ready_o,
  input  logic [N*WI-1:0] oup_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic [N*WI-1:0] mem_wdata_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     stall_cnt_o
);

  localparam int unsigned DW         = N * WI;
  localparam int unsigned TILE_BYTES = DW / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [AW-1:0] row_stride_q;
  logic [CW-1:0] num_rows_q, num_col_tiles_q;
  logic [AW-1:0] row_ptr_q, row_ptr_d;
  logic [AW-1:0] tile_ptr_q, tile_ptr_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] tile_cnt_q, tile_cnt_d;

  entry_t        fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;

  logic          cfg_load;
  logic          push, pop;

  assign cfg_load    = (state_q == IDLE) && start_i;
  assign oup_ready_o = (state_q == RUN) && (cnt_q != 2'd2);
  assign push        = oup_valid_i && oup_ready_o;
  assign mem_req_o   = (cnt_q != 2'd0);
  assign pop         = mem_req_o && mem_gnt_i;
  assign mem_addr_o  = fifo_q[rd_ptr_q].addr;
  assign mem_wdata_o = fifo_q[rd_ptr_q].data;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  // Next state, address walk and FIFO occupancy
  always_comb begin
    state_d    = state_q;
    row_ptr_d  = row_ptr_q;
    tile_ptr_d = tile_ptr_q;
    row_cnt_d  = row_cnt_q;
    tile_cnt_d = tile_cnt_q;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          row_ptr_d  = base_addr_i;
          tile_ptr_d = base_addr_i;
          row_cnt_d  = '0;
          tile_cnt_d = '0;
          if ((num_rows_i == '0) || (num_col_tiles_i == '0)) state_d = DONE;
          else                                               state_d = RUN;
        end
      end
      RUN: begin
        if (push) begin
          if (row_cnt_q == num_rows_q - CW'(1)) begin
            // Row wrap: step to the next column tile and restart its rows
            row_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + CW'(1);
            tile_ptr_d = tile_ptr_q + AW'(TILE_BYTES);
            row_ptr_d  = tile_ptr_q + AW'(TILE_BYTES);
            if (tile_cnt_q == num_col_tiles_q - CW'(1)) state_d = DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
            row_ptr_d = row_ptr_q + row_stride_q;
          end
        end
      end
      // Leave as soon as the final grant empties the buffer
      DRAIN:   if (cnt_d == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointers and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_ptr_q  <= '0;
      tile_ptr_q <= '0;
      row_cnt_q  <= '0;
      tile_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      tile_ptr_q <= tile_ptr_d;
      row_cnt_q  <= row_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Job configuration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_stride_q    <= '0;
      num_rows_q      <= '0;
      num_col_tiles_q <= '0;
    end else if (cfg_load) begin
      row_stride_q    <= row_stride_i;
      num_rows_q      <= num_rows_i;
      num_col_tiles_q <= num_col_tiles_i;
    end
  end

  // Two-entry {addr, data} buffer between stream and memory
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{addr: row_ptr_q, data: oup_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef ITA_OUTPUT_WRITER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where a request waits for its grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                          stall_cnt_q <= '0;
    else if (cfg_load)                                    stall_cnt_q <= '0;
    else if (mem_req_o && !mem_gnt_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ita_output_writer.sv
module tb_ita_output_writer;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [31:0]   row_stride_i;
  logic [15:0]   num_rows_i;
  logic [15:0]   num_col_tiles_i;
  logic          oup_valid_i;
  logic          oup_ready_o;
  logic [127:0]  oup_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [31:0]   mem_addr_o;
  logic [127:0]  mem_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_job
  logic [31:0]  got_addr [$];
  logic [127:0] got_data [$];
  int first_req_iter, first_grant_iter, last_grant_iter, done_iter;
  int done_pulses, req_seen, stall_unstable, ready_low_seen;
  logic ready_at1, busy_after_done, timeout;

  logic [31:0] exp_basic [8] = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0,
                                 32'h1010, 32'h1050, 32'h1090, 32'h10D0};

  ita_output_writer dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .row_stride_i    (row_stride_i),
    .num_rows_i      (num_rows_i),
    .num_col_tiles_i (num_col_tiles_i),
    .oup_valid_i     (oup_valid_i),
    .oup_ready_o     (oup_ready_o),
    .oup_i           (oup_i),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] data_of(input int k);
    logic [127:0] d;
    for (int l = 0; l < 16; l++) d[l*8 +: 8] = 8'(k * 16 + l + 1);
    return d;
  endfunction

  // Drives one job: start at iteration 0, stream beats from iteration 1, memory
  // sink withholding gnt for stall_len cycles when granting beat stall_beat.
  // Each iteration runs 1 time unit after a rising edge.
  task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                         input logic [15:0] rows, input logic [15:0] tiles,
                         input int stall_beat, input int stall_len,
                         input int restart_iter, input int abort_grants);
    int total, sent, granted, stalled;
    logic gnt, prev_stall;
    logic [31:0] prev_addr;
    logic [127:0] prev_data;
    got_addr.delete();
    got_data.delete();
    total = int'(rows) * int'(tiles);
    sent = 0; granted = 0; stalled = 0;
    first_req_iter = -1; first_grant_iter = -1; last_grant_iter = -1; done_iter = -1;
    done_pulses = 0; req_seen = 0; stall_unstable = 0; ready_low_seen = 0;
    ready_at1 = 1'b0; busy_after_done = 1'b1; timeout = 1'b1; prev_stall = 1'b0;
    prev_addr = '0; prev_data = '0;
    @(posedge clk_i); #1;
    base_addr_i = base; row_stride_i = stride;
    num_rows_i = rows; num_col_tiles_i = tiles;
    start_i = 1'b1;
    for (int it = 1; it <= 300; it++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (it == restart_iter) begin
        start_i = 1'b1;
        base_addr_i = 32'hDEAD_0000; row_stride_i = 32'h4;
        num_rows_i = 16'd1; num_col_tiles_i = 16'd1;
      end
      if (it == 1) ready_at1 = oup_ready_o;
      if (prev_stall && (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data))
        stall_unstable++;
      if (mem_req_o) begin
        req_seen++;
        if (first_req_iter < 0) first_req_iter = it;
      end
      if (done_o) begin
        done_pulses++;
        if (done_iter < 0) done_iter = it;
      end
      if (done_iter >= 0 && it == done_iter + 1) begin
        busy_after_done = busy_o;
        timeout = 1'b0;
        break;
      end
      gnt = !(mem_req_o && granted == stall_beat && stalled < stall_len);
      if (mem_req_o && !gnt) stalled++;
      mem_gnt_i = gnt;
      prev_stall = mem_req_o && !gnt;
      prev_addr = mem_addr_o;
      prev_data = mem_wdata_o;
      if (mem_req_o && gnt) begin
        got_addr.push_back(mem_addr_o);
        got_data.push_back(mem_wdata_o);
        if (first_grant_iter < 0) first_grant_iter = it;
        last_grant_iter = it;
        granted++;
        if (granted == abort_grants) begin
          timeout = 1'b0;
          return;
        end
      end
      oup_valid_i = (sent < total);
      oup_i = data_of(sent);
      if (oup_valid_i && oup_ready_o) sent++;
      else if (oup_valid_i) ready_low_seen++;
    end
    oup_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b0; base_addr_i = '0; row_stride_i = '0;
    num_rows_i = '0; num_col_tiles_i = '0;
    oup_valid_i = 1'b0; oup_i = '0; mem_gnt_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if ({oup_ready_o, mem_req_o, busy_o, done_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {oup_ready_o, mem_req_o, busy_o, done_o}); end
    checks++; if (mem_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 128'h0) begin
      errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
    checks++; if (stall_cnt_o !== 32'h0) begin
      errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic_job();
    run_job(32'h1000, 32'h40, 16'd4, 16'd2, -1, 0, -1, -1);
    checks++; if (timeout !== 1'b0) begin
      errors++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
    checks++; if (ready_at1 !== 1'b1) begin
      errors++; $display("FAIL basic_ready_after_start: got %b expected 1", ready_at1); end
    checks++; if (first_req_iter !== 2) begin
      errors++; $display("FAIL basic_first_req: got %0d expected 2", first_req_iter); end
    checks++; if (got_addr.size() !== 8) begin
      errors++; $display("FAIL basic_count: got %0d expected 8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_basic[i]) begin
        errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, got_addr[i], exp_basic[i]); end
      checks++; if (got_data[i] !== data_of(i)) begin
        errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], data_of(i)); end
    end
    checks++; if (last_grant_iter - first_grant_iter !== 7) begin
      errors++; $display("FAIL back_to_back_span: got %0d expected 7", last_grant_iter - first_grant_iter); end
    checks++; if (ready_low_seen !== 0) begin
      errors++; $display("FAIL back_to_back_ready: got %0d expected 0", ready_low_seen); end
    checks++; if (done_iter !== last_grant_iter + 1) begin
      errors++; $display("FAIL basic_done_time: got %0d expected %0d", done_iter, last_grant_iter + 1); end
    checks++; if (done_pulses !== 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (busy_after_done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy_after_done); end
    checks++; if (stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL basic_stall_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_stall;
`ifdef ITA_OUTPUT_WRITER_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    run_job(32'h1000, 32'h40, 16'd4, 16'd2, 2, 5, -1, -1);
    checks++; if (got_addr.size() !== 8 || timeout !== 1'b0) begin
      errors++; $display("FAIL stall_count: got %0d beats timeout %b expected 8 beats", got_addr.size(), timeout); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_basic[i] || got_data[i] !== data_of(i)) begin
        errors++; $display("FAIL stall_beat[%0d]: got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_basic[i], data_of(i)); end
    end
    checks++; if (ready_low_seen == 0) begin
      errors++; $display("FAIL stall_ready_drop: got %0d low cycles expected >0", ready_low_seen); end
    checks++; if (stall_unstable !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_unstable); end
    checks++; if (stall_cnt_o !== exp_stall) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt_o, exp_stall); end
  endtask

  task automatic test_zero_size();
    run_job(32'h2000, 32'h40, 16'd0, 16'd3, -1, 0, -1, -1);
    checks++; if (done_iter !== 1) begin
      errors++; $display("FAIL zero_done_time: got %0d expected 1", done_iter); end
    checks++; if (req_seen !== 0) begin
      errors++; $display("FAIL zero_no_req: got %0d expected 0", req_seen); end
    checks++; if (busy_after_done !== 1'b0) begin
      errors++; $display("FAIL zero_busy_idle: got %b expected 0", busy_after_done); end
  endtask

  task automatic test_addr_wrap();
    run_job(32'hFFFF_FFF0, 32'h20, 16'd2, 16'd1, -1, 0, -1, -1);
    checks++; if (got_addr.size() !== 2) begin
      errors++; $display("FAIL wrap_count: got %0d expected 2", got_addr.size()); end
    else begin
      checks++; if (got_addr[0] !== 32'hFFFF_FFF0) begin
        errors++; $display("FAIL wrap_addr0: got %h expected FFFFFFF0", got_addr[0]); end
      checks++; if (got_addr[1] !== 32'h0000_0010) begin
        errors++; $display("FAIL wrap_addr1: got %h expected 00000010", got_addr[1]); end
    end
  endtask

  task automatic test_reset_mid_job();
    run_job(32'h1000, 32'h40, 16'd4, 16'd2, -1, 0, -1, 3);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    oup_valid_i = 1'b0;
    #1;
    checks++; if ({oup_ready_o, mem_req_o, busy_o, done_o} !== 4'b0000) begin
      errors++; $display("FAIL midreset_ctrl: got %b expected 0000", {oup_ready_o, mem_req_o, busy_o, done_o}); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 128'h0 || stall_cnt_o !== 32'h0) begin
      errors++; $display("FAIL midreset_data: got %h/%h/%0d expected zeros", mem_addr_o, mem_wdata_o, stall_cnt_o); end
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if ({mem_req_o, done_o} !== 2'b00) begin
      errors++; $display("FAIL midreset_hold: got %b expected 00", {mem_req_o, done_o}); end
    rst_ni = 1'b1;
    run_job(32'h1000, 32'h40, 16'd4, 16'd2, -1, 0, -1, -1);
    checks++; if (got_addr.size() !== 8 || timeout !== 1'b0) begin
      errors++; $display("FAIL midreset_rerun_count: got %0d expected 8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_basic[i] || got_data[i] !== data_of(i)) begin
        errors++; $display("FAIL midreset_rerun[%0d]: got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_basic[i], data_of(i)); end
    end
  endtask

  task automatic test_start_in_run();
    run_job(32'h1000, 32'h40, 16'd4, 16'd2, -1, 0, 3, -1);
    checks++; if (got_addr.size() !== 8 || timeout !== 1'b0) begin
      errors++; $display("FAIL restart_count: got %0d expected 8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_basic[i]) begin
        errors++; $display("FAIL restart_addr[%0d]: got %h expected %h", i, got_addr[i], exp_basic[i]); end
    end
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if ({busy_o, mem_req_o} !== 2'b00) begin
      errors++; $display("FAIL restart_idle: got %b expected 00", {busy_o, mem_req_o}); end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_stall();
    test_zero_size();
    test_addr_wrap();
    test_reset_mid_job();
    test_start_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ita_output_writer.md
# ita_output_writer

Stream-to-memory writer on the output side of the ITA accelerator. It accepts the ITA result stream (valid/ready, one N-lane row-segment of WI-bit requantized values per beat) and writes each beat to memory through a single-port req/gnt write interface. Addresses are generated for a tiled row-major output matrix. It is the consuming end of ITA's `valid_o`/`ready_i`/`oup_o` output handshake and replaces the testbench-side sink in system integrations.

## Interface
- `N`, 16: lanes per beat.
- `WI`, 8: bits per lane.
- `AW`, 32: memory address width.
- `CW`, 16: row/tile counter width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: single-cycle job start; sampled only in IDLE.
- `base_addr_i` in AW: byte address of element (0,0); latched on start.
- `row_stride_i` in AW: byte distance between consecutive rows; latched on start.
- `num_rows_i` in CW: rows per column tile; latched on start.
- `num_col_tiles_i` in CW: column tiles, each N lanes wide; latched on start.
- `oup_valid_i` in 1: ITA output beat valid.
- `oup_ready_o` out 1: beat accepted when valid and ready are both high.
- `oup_i` in N*WI: beat data; lane 0 in bits [WI-1:0].
- `mem_req_o` out 1: write request.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_addr_o` out AW: byte address of the beat.
- `mem_wdata_o` out N*WI: beat data.
- `busy_o` out 1: high from start acceptance until the cycle after the last grant.
- `done_o` out 1: one-cycle pulse at job end.
- `stall_cnt_o` out 32: count of cycles with `mem_req_o` high and `mem_gnt_i` low.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start_i--> RUN. Config is latched; counters are cleared. If `num_rows_i`==0 or `num_col_tiles_i`==0, the transition goes to DONE instead.
  - RUN --last beat accepted--> DRAIN.
  - DRAIN --buffer empty and no outstanding request--> DONE.
  - DONE --> IDLE unconditionally; `done_o`=1 in the DONE cycle.
- Beat order:
  - Column tile is the outer loop, row is the inner loop.
  - Beat k maps to row r = k mod num_rows and tile c = k div num_rows.
  - addr = base + r*row_stride + c*(N*WI/8).
  - Address is computed incrementally: a row pointer adds `row_stride` each beat. At row wrap, a tile pointer adds N*WI/8 and the row pointer reloads from the tile pointer.
  - No multiplier.
- Address arithmetic is modulo 2^AW; overflow wraps silently.
- 2-entry FIFO holds {addr, data} between the stream side and the memory side.
- `oup_ready_o` = (state==RUN) && FIFO not full. It has no combinational dependence on `mem_gnt_i` or `oup_valid_i`.
- Memory side:
  - `mem_req_o` = FIFO not empty.
  - addr/data come from the FIFO head.
  - Pop on `mem_gnt_i`.
  - While req is high without gnt, addr/data stay stable.
- Simultaneous push and pop with FIFO holding 1 entry: occupancy stays 1. With FIFO full, no push is possible (ready is low that cycle).
- `start_i` outside IDLE is ignored. `oup_valid_i` outside RUN is not accepted.

## Timing
- Reset values:
  - `oup_ready_o`=0, `mem_req_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
  - `busy_o`=0, `done_o`=0, `stall_cnt_o`=0.
  - FSM=IDLE, FIFO empty.
- `start_i` at cycle t: RUN and `oup_ready_o`=1 from t+1.
- Beat accepted at cycle t: `mem_req_o` for it is high from t+1 at the earliest.
- Sustained throughput is 1 beat/cycle when `mem_gnt_i` is held high.
- Last grant at cycle t: DONE with `done_o`=1 at t+1, IDLE at t+2.
- Zero-size job: start at t gives `done_o`=1 at t+1, with no `mem_req_o`.
- Reset asserted mid-job: all state cleared immediately. Pending FIFO entries are dropped and no `done_o` is issued.

## Configuration
- `ITA_OUTPUT_WRITER_STALL_CNT_EN`:
  - Defined: `stall_cnt_o` counts grant-stall cycles, saturating at 2^32-1, cleared on job start.
  - Undefined: the counter is not built and `stall_cnt_o` is tied to 0.

## Test plan
- N=16, WI=8, base=0x1000, stride=0x40, rows=4, tiles=2, gnt always 1:
  - Addresses are 0x1000, 0x1040, 0x1080, 0x10C0, 0x1010, 0x1050, 0x1090, 0x10D0.
  - Back-to-back beats give one req per cycle.
  - `done_o` fires 1 cycle after the 8th grant.
- Same job with gnt low for 5 cycles at beat 2:
  - `oup_ready_o` drops after 2 buffered beats.
  - addr/data stay stable while stalled.
  - No beat is lost or duplicated.
  - `stall_cnt_o`=5 with the macro defined, 0 without it.
- rows=0, tiles=3: `done_o` pulses at start+1 and `mem_req_o` never rises.
- base=0xFFFF_FFF0, stride=0x20, rows=2, tiles=1: addresses are 0xFFFF_FFF0, then 0x0000_0010 (wrap).
- Reset asserted after beat 3 of an 8-beat job:
  - All outputs return to reset values.
  - A new start afterwards produces a correct full job from beat 0.
- `start_i` pulsed during RUN: ignored, and job addresses are unchanged.
